// File: rtl/vending_controller_pkg.sv
// Shared definitions for the vending controller slice.
//   state_t   : controller FSM states (IDLE, VEND, CHANGE)
//   id_width  : product id width for a given product count (min 1 bit)
//   ID_W      : id width for the default four-product configuration
//   price     : product price derived from base price and per-id step
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_W = id_width(4);

    function automatic int unsigned price(input int unsigned id,
                                          input int unsigned base,
                                          input int unsigned step);
        return base + id * step;
    endfunction

endpackage

// File: rtl/vending_controller_stock.sv
// Per-product stock counters.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_dec_en, i_dec_id        : take one unit of product i_dec_id
//   i_restock_en, i_restock_id: refill product to STOCK_MAX (beats a decrement)
//   o_nonzero                 : bit i set when product i has stock
module stock_bank #(
    parameter int unsigned N_DRINKS = 4,
    parameter int unsigned SW       = 4,
    parameter int unsigned IDW      = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_dec_en,
    input  logic [IDW-1:0]      i_dec_id,
    input  logic                i_restock_en,
    input  logic [IDW-1:0]      i_restock_id,
    output logic [N_DRINKS-1:0] o_nonzero
);

    logic [SW-1:0] r_stock [N_DRINKS];

    // Ids outside 0..N_DRINKS-1 match no counter and are therefore ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < N_DRINKS; i++) begin
                r_stock[i] <= '1;
            end
        end else begin
            for (int unsigned i = 0; i < N_DRINKS; i++) begin
                if (i_restock_en && (i_restock_id == IDW'(i))) begin
                    r_stock[i] <= '1;
                end else if (i_dec_en && (i_dec_id == IDW'(i))) begin
                    r_stock[i] <= r_stock[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_nonzero = '0;
        for (int unsigned i = 0; i < N_DRINKS; i++) begin
            o_nonzero[i] = (r_stock[i] != '0);
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Multi-product vending controller.
//   clk, rst (async active-low)
//   coin_valid/coin -> coin_reject    : coin credit with overflow rejection
//   sel_valid/sel_id -> deny          : product selection
//   refund_req                        : return all credit via change handshake
//   restock_valid/restock_id          : refill one product
//   dispense_valid/id/ready           : dispense handshake
//   change_valid/amount/ready         : change handshake
//   credit, avail                     : current credit, affordable-and-stocked mask
module vending_controller
    import vend_pkg::*;
#(
    parameter  int unsigned N_DRINKS   = 4,
    parameter  int unsigned CW         = 8,
    parameter  int unsigned PRICE_BASE = 10,
    parameter  int unsigned PRICE_STEP = 5,
    parameter  int unsigned SW         = 4,
    localparam int unsigned IDW        = id_width(N_DRINKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [CW-1:0]       coin,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [IDW-1:0]      sel_id,
    output logic                deny,
    input  logic                refund_req,
    input  logic                restock_valid,
    input  logic [IDW-1:0]      restock_id,
    output logic                dispense_valid,
    output logic [IDW-1:0]      dispense_id,
    input  logic                dispense_ready,
    output logic                change_valid,
    output logic [CW-1:0]       change_amount,
    input  logic                change_ready,
    output logic [CW-1:0]       credit,
    output logic [N_DRINKS-1:0] avail
);

    state_t                r_state;
    logic [CW-1:0]         r_credit;
    logic [IDW-1:0]        r_dispense_id;
    logic [CW-1:0]         r_change_amount;
    logic                  r_dispense_valid;
    logic                  r_change_valid;
    logic                  r_deny;
    logic                  r_coin_reject;

    logic [N_DRINKS-1:0]   w_nonzero;
    logic [CW:0]           w_sum;
    logic                  w_sel_in_range;
    logic                  w_sel_stock;
    logic [CW-1:0]         w_price;
    logic                  w_sel_ok;
    logic                  w_dec_en;

    // Extra carry bit flags a coin that would wrap the credit register.
    assign w_sum          = {1'b0, r_credit} + {1'b0, coin};
    assign w_sel_in_range = (32'(sel_id) < N_DRINKS);
    assign w_sel_stock    = w_sel_in_range && w_nonzero[sel_id];
    assign w_price        = CW'(price(32'(sel_id), PRICE_BASE, PRICE_STEP));
    assign w_sel_ok       = w_sel_stock && (r_credit >= w_price);
    assign w_dec_en       = (r_state == IDLE) && sel_valid && w_sel_ok;

    stock_bank #(
        .N_DRINKS (N_DRINKS),
        .SW       (SW),
        .IDW      (IDW)
    ) u_stock (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_dec_en     (w_dec_en),
        .i_dec_id     (sel_id),
        .i_restock_en (restock_valid),
        .i_restock_id (restock_id),
        .o_nonzero    (w_nonzero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_credit         <= '0;
            r_dispense_id    <= '0;
            r_change_amount  <= '0;
            r_dispense_valid <= 1'b0;
            r_change_valid   <= 1'b0;
            r_deny           <= 1'b0;
            r_coin_reject    <= 1'b0;
        end else begin
            r_deny        <= 1'b0;
            r_coin_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Priority select > refund > coin; a coin that loses
                    // to a handled select/refund is bounced, not queued.
                    if (sel_valid) begin
                        r_coin_reject <= coin_valid;
                        if (w_sel_ok) begin
                            r_credit         <= r_credit - w_price;
                            r_dispense_id    <= sel_id;
                            r_dispense_valid <= 1'b1;
                            r_state          <= VEND;
                        end else begin
                            r_deny <= 1'b1;
                        end
                    end else if (refund_req && (r_credit != '0)) begin
                        r_coin_reject   <= coin_valid;
                        r_change_amount <= r_credit;
                        r_change_valid  <= 1'b1;
                        r_state         <= CHANGE;
                    end else if (coin_valid) begin
                        if (w_sum[CW]) begin
                            r_coin_reject <= 1'b1;
                        end else begin
                            r_credit <= w_sum[CW-1:0];
                        end
                    end
                end
                VEND: begin
                    r_coin_reject <= coin_valid;
                    if (dispense_ready) begin
                        r_dispense_valid <= 1'b0;
                        r_state          <= IDLE;
                    end
                end
                CHANGE: begin
                    r_coin_reject <= coin_valid;
                    if (change_ready) begin
                        r_credit       <= '0;
                        r_change_valid <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        avail = '0;
        for (int unsigned i = 0; i < N_DRINKS; i++) begin
            avail[i] = w_nonzero[i] &&
                       (r_credit >= CW'(price(i, PRICE_BASE, PRICE_STEP)));
        end
    end

    assign coin_reject    = r_coin_reject;
    assign deny           = r_deny;
    assign dispense_valid = r_dispense_valid;
    assign dispense_id    = r_dispense_id;
    assign change_valid   = r_change_valid;
    assign change_amount  = r_change_amount;
    assign credit         = r_credit;

endmodule

// File: tb/tb_vending_controller.sv
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin = '0;
    logic       coin_reject;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = '0;
    logic       deny;
    logic       refund_req = 1'b0;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_id = '0;
    logic       dispense_valid;
    logic [1:0] dispense_id;
    logic       dispense_ready = 1'b0;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       change_ready = 1'b0;
    logic [7:0] credit;
    logic [3:0] avail;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vending_controller #(
        .N_DRINKS   (4),
        .CW         (8),
        .PRICE_BASE (10),
        .PRICE_STEP (5),
        .SW         (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coin_valid     (coin_valid),
        .coin           (coin),
        .coin_reject    (coin_reject),
        .sel_valid      (sel_valid),
        .sel_id         (sel_id),
        .deny           (deny),
        .refund_req     (refund_req),
        .restock_valid  (restock_valid),
        .restock_id     (restock_id),
        .dispense_valid (dispense_valid),
        .dispense_id    (dispense_id),
        .dispense_ready (dispense_ready),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .change_ready   (change_ready),
        .credit         (credit),
        .avail          (avail)
    );

    typedef struct {
        logic       cv;
        logic [7:0] coin;
        logic       sv;
        logic [1:0] sid;
        logic       rf;
        logic       rsv;
        logic [1:0] rsid;
        logic       dr;
        logic       cr;
        logic [7:0] e_credit;
        logic       e_dv;
        logic [1:0] e_did;
        logic       e_cv;
        logic [7:0] e_camt;
        logic       e_deny;
        logic       e_rej;
        logic [3:0] e_avail;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Inputs are applied #1 after an edge, held across the next edge, then cleared.
    task automatic step(input logic cv, input logic [7:0] c, input logic sv,
                        input logic [1:0] sid, input logic rf, input logic rsv,
                        input logic [1:0] rsid, input logic dr, input logic cr);
        coin_valid = cv; coin = c; sel_valid = sv; sel_id = sid;
        refund_req = rf; restock_valid = rsv; restock_id = rsid;
        dispense_ready = dr; change_ready = cr;
        @(posedge clk);
        #1;
        coin_valid = 0; coin = 0; sel_valid = 0; sel_id = 0;
        refund_req = 0; restock_valid = 0; restock_id = 0;
        dispense_ready = 0; change_ready = 0;
    endtask

    task automatic idle_step();
        step(0, 8'd0, 0, 2'd0, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        //          cv coin sv sid rf rsv rsid dr cr | credit dv did cv camt deny rej avail
        vecs.push_back('{1, 8'd10, 0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd10, 0, 2'd0, 0, 8'd0,  0, 0, 4'b0001});
        vecs.push_back('{1, 8'd5,  0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd15, 0, 2'd0, 0, 8'd0,  0, 0, 4'b0011});
        vecs.push_back('{1, 8'd5,  0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd20, 0, 2'd0, 0, 8'd0,  0, 0, 4'b0111});
        vecs.push_back('{0, 8'd0,  1, 2'd2, 0, 0, 2'd0, 0, 0,  8'd0,  1, 2'd2, 0, 8'd0,  0, 0, 4'b0000});
        vecs.push_back('{0, 8'd0,  0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd0,  1, 2'd2, 0, 8'd0,  0, 0, 4'b0000});
        vecs.push_back('{1, 8'd5,  0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd0,  1, 2'd2, 0, 8'd0,  0, 1, 4'b0000});
        vecs.push_back('{0, 8'd0,  0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd0,  1, 2'd2, 0, 8'd0,  0, 0, 4'b0000});
        vecs.push_back('{0, 8'd0,  0, 2'd0, 0, 0, 2'd0, 1, 0,  8'd0,  0, 2'd2, 0, 8'd0,  0, 0, 4'b0000});
        vecs.push_back('{1, 8'd12, 0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd12, 0, 2'd2, 0, 8'd0,  0, 0, 4'b0001});
        vecs.push_back('{0, 8'd0,  1, 2'd1, 0, 0, 2'd0, 0, 0,  8'd12, 0, 2'd2, 0, 8'd0,  1, 0, 4'b0001});
        vecs.push_back('{0, 8'd0,  0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd12, 0, 2'd2, 0, 8'd0,  0, 0, 4'b0001});
        vecs.push_back('{0, 8'd0,  0, 2'd0, 1, 0, 2'd0, 0, 0,  8'd12, 0, 2'd2, 1, 8'd12, 0, 0, 4'b0001});
        vecs.push_back('{0, 8'd0,  0, 2'd0, 0, 0, 2'd0, 0, 1,  8'd0,  0, 2'd2, 0, 8'd12, 0, 0, 4'b0000});
        vecs.push_back('{1, 8'd20, 0, 2'd0, 0, 0, 2'd0, 0, 0,  8'd20, 0, 2'd2, 0, 8'd12, 0, 0, 4'b0111});
        vecs.push_back('{1, 8'd5,  1, 2'd0, 1, 0, 2'd0, 0, 0,  8'd10, 1, 2'd0, 0, 8'd12, 0, 1, 4'b0001});
        vecs.push_back('{0, 8'd0,  0, 2'd0, 0, 0, 2'd0, 1, 0,  8'd10, 0, 2'd0, 0, 8'd12, 0, 0, 4'b0001});

        do_reset();
        chk("reset_credit", credit, 0);
        chk("reset_dvalid", dispense_valid, 0);
        chk("reset_cvalid", change_valid, 0);
        chk("reset_deny", deny, 0);
        chk("reset_reject", coin_reject, 0);
        chk("reset_did", dispense_id, 0);
        chk("reset_camt", change_amount, 0);
        chk("reset_avail", avail, 0);

        foreach (vecs[i]) begin
            step(vecs[i].cv, vecs[i].coin, vecs[i].sv, vecs[i].sid, vecs[i].rf,
                 vecs[i].rsv, vecs[i].rsid, vecs[i].dr, vecs[i].cr);
            chk($sformatf("v%0d_credit", i), credit, vecs[i].e_credit);
            chk($sformatf("v%0d_dvalid", i), dispense_valid, vecs[i].e_dv);
            chk($sformatf("v%0d_did", i), dispense_id, vecs[i].e_did);
            chk($sformatf("v%0d_cvalid", i), change_valid, vecs[i].e_cv);
            chk($sformatf("v%0d_camt", i), change_amount, vecs[i].e_camt);
            chk($sformatf("v%0d_deny", i), deny, vecs[i].e_deny);
            chk($sformatf("v%0d_reject", i), coin_reject, vecs[i].e_rej);
            chk($sformatf("v%0d_avail", i), avail, vecs[i].e_avail);
        end

        // Overflow: credit 10 -> 250, then a 10 coin would wrap past 255.
        step(1, 8'd240, 0, 2'd0, 0, 0, 2'd0, 0, 0);
        chk("ovf_credit250", credit, 250);
        step(1, 8'd10, 0, 2'd0, 0, 0, 2'd0, 0, 0);
        chk("ovf_reject", coin_reject, 1);
        chk("ovf_credit_kept", credit, 250);
        idle_step();
        chk("ovf_reject_pulse_end", coin_reject, 0);
        step(0, 8'd0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        chk("ovf_cvalid", change_valid, 1);
        chk("ovf_camt", change_amount, 250);
        idle_step();
        chk("ovf_cvalid_held", change_valid, 1);
        chk("ovf_credit_held", credit, 250);
        step(0, 8'd0, 0, 2'd0, 0, 0, 2'd0, 0, 1);
        chk("ovf_cvalid_drop", change_valid, 0);
        chk("ovf_credit_cleared", credit, 0);

        // Refund with zero credit is ignored.
        step(0, 8'd0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        chk("refund_zero_ignored", change_valid, 0);

        // Stock exhaustion of product 0 from a fresh reset.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            step(1, 8'd10, 0, 2'd0, 0, 0, 2'd0, 0, 0);
            step(0, 8'd0, 1, 2'd0, 0, 0, 2'd0, 0, 0);
            chk($sformatf("buy%0d_dvalid", k), dispense_valid, 1);
            step(0, 8'd0, 0, 2'd0, 0, 0, 2'd0, 1, 0);
        end
        step(1, 8'd10, 0, 2'd0, 0, 0, 2'd0, 0, 0);
        chk("empty_credit", credit, 10);
        chk("empty_avail", avail, 4'b0000);
        step(0, 8'd0, 1, 2'd0, 0, 0, 2'd0, 0, 0);
        chk("empty_deny", deny, 1);
        chk("empty_no_vend", dispense_valid, 0);
        chk("empty_credit_kept", credit, 10);
        step(0, 8'd0, 0, 2'd0, 0, 1, 2'd0, 0, 0);
        chk("restock_avail", avail, 4'b0001);

        // Reset while a change payout is pending.
        step(0, 8'd0, 0, 2'd0, 1, 0, 2'd0, 0, 0);
        chk("pre_rst_cvalid", change_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_cvalid", change_valid, 0);
        chk("async_rst_credit", credit, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cvalid", change_valid, 0);
        chk("post_rst_credit", credit, 0);
        step(1, 8'd25, 0, 2'd0, 0, 0, 2'd0, 0, 0);
        chk("post_rst_avail_all", avail, 4'b1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
